// File: rtl/clk_tick_gen.sv
// clk_tick_gen
//   Timebase for the digital clock. Divides clk_100M down to a base tick
//   (BASE_HZ, display scan) and further to a 1 Hz tick (timekeeping). It also
//   provides a 50% duty 1 Hz square wave and a runtime-programmable tick
//   channel. Every tick is a single-cycle clock enable, not a clock.
//
//   Ports
//     clk_100M   in   system clock, all logic on rising edge
//     sys_rst_p  in   asynchronous active-high reset
//     en         in   1 = count, 0 = freeze all counters (ticks forced low)
//     sync_clr   in   synchronous phase clear of all counters (wins over en)
//     fast       in   1 = tick_1Hz on every base tick (time setting)
//     div_load   in   load div_in into the programmable divisor
//     div_in     in   new divisor, in base ticks (0 = channel off)
//     tick_base  out  1-cycle pulse at BASE_HZ
//     tick_1Hz   out  1-cycle pulse at 1 Hz, coincident with a tick_base
//     sq_1Hz     out  1 Hz square wave, 50% duty
//     tick_prog  out  1-cycle pulse every div_q base ticks
module clk_tick_gen #(
    parameter int unsigned CLK_FREQ_HZ  = 100_000_000,
    parameter int unsigned BASE_HZ      = 1000,
    parameter int unsigned PROG_W       = 16,
    parameter int unsigned PROG_DEFAULT = 500
) (
    input  logic              clk_100M,
    input  logic              sys_rst_p,
    input  logic              en,
    input  logic              sync_clr,
    input  logic              fast,
    input  logic              div_load,
    input  logic [PROG_W-1:0] div_in,
    output logic              tick_base,
    output logic              tick_1Hz,
    output logic              sq_1Hz,
    output logic              tick_prog
);

    localparam int unsigned PRE_DIV = CLK_FREQ_HZ / BASE_HZ;
    localparam int unsigned PRE_W   = $clog2(PRE_DIV);
    localparam int unsigned SEC_W   = $clog2(BASE_HZ);

    localparam logic [PRE_W-1:0]  PRE_MAX  = PRE_W'(PRE_DIV - 1);
    localparam logic [SEC_W-1:0]  SEC_MAX  = SEC_W'(BASE_HZ - 1);
    localparam logic [SEC_W-1:0]  SEC_HALF = SEC_W'(BASE_HZ / 2);
    localparam logic [PROG_W-1:0] DIV_RST  = PROG_W'(PROG_DEFAULT);

    if (CLK_FREQ_HZ % BASE_HZ != 0) begin : g_chk_ratio
        $error("clk_tick_gen: CLK_FREQ_HZ must be a multiple of BASE_HZ");
    end
    if (PRE_DIV < 2) begin : g_chk_prediv
        $error("clk_tick_gen: CLK_FREQ_HZ/BASE_HZ must be at least 2");
    end
    if ((BASE_HZ < 2) || (BASE_HZ % 2 != 0)) begin : g_chk_base
        $error("clk_tick_gen: BASE_HZ must be even and at least 2");
    end

    logic [PRE_W-1:0]  pre_cnt;
    logic [SEC_W-1:0]  sec_cnt;
    logic [PROG_W-1:0] prog_cnt;
    logic [PROG_W-1:0] div_q;

    logic pre_wrap;
    logic sec_wrap;
    logic prog_on;
    logic prog_wrap;

    always_comb begin
        pre_wrap  = (pre_cnt == PRE_MAX);
        sec_wrap  = (sec_cnt == SEC_MAX);
        prog_on   = (div_q != '0);
        prog_wrap = prog_on && (prog_cnt == (div_q - PROG_W'(1)));
    end

    always_ff @(posedge clk_100M or posedge sys_rst_p) begin
        if (sys_rst_p) begin
            pre_cnt   <= '0;
            sec_cnt   <= '0;
            prog_cnt  <= '0;
            div_q     <= DIV_RST;
            tick_base <= 1'b0;
            tick_1Hz  <= 1'b0;
            sq_1Hz    <= 1'b0;
            tick_prog <= 1'b0;
        end else begin
            tick_base <= 1'b0;
            tick_1Hz  <= 1'b0;
            tick_prog <= 1'b0;

            if (sync_clr) begin
                pre_cnt  <= '0;
                sec_cnt  <= '0;
                prog_cnt <= '0;
                sq_1Hz   <= 1'b0;
            end else if (en) begin
                sq_1Hz <= (sec_cnt >= SEC_HALF);
                if (pre_wrap) begin
                    pre_cnt   <= '0;
                    tick_base <= 1'b1;
                    // fast pins sec_cnt at 0, so a full second follows its release
                    if (fast || sec_wrap) begin
                        sec_cnt  <= '0;
                        tick_1Hz <= 1'b1;
                    end else begin
                        sec_cnt <= sec_cnt + SEC_W'(1);
                    end
                    if (prog_wrap) begin
                        prog_cnt  <= '0;
                        tick_prog <= 1'b1;
                    end else if (prog_on) begin
                        prog_cnt <= prog_cnt + PROG_W'(1);
                    end
                end else begin
                    pre_cnt <= pre_cnt + PRE_W'(1);
                    if (fast) begin
                        sec_cnt <= '0;
                    end
                end
            end

            // Placed last so it overrides the prog_cnt update above; a wrap
            // in the same cycle still emits its tick_prog from the old divisor.
            if (div_load) begin
                div_q    <= div_in;
                prog_cnt <= '0;
            end
        end
    end

endmodule
